// File: rtl/k12a_uart_loader.sv
// k12a_uart_loader: serial boot loader for the k12a core.
// Receives an 8N1 framed image (0x55, LEN_HI, LEN_LO, data..., CHK) on uart_rx,
// writes the data bytes into program memory and releases the core after a good checksum.
// Ports:
//   cpu_clock  - single rising-edge clock
//   reset_n    - asynchronous active-low reset
//   uart_rx    - serial input, idles high, asynchronous to cpu_clock
//   mem_addr   - program memory write address
//   mem_data   - program memory write data
//   mem_we     - one-cycle write strobe
//   cpu_run    - 1 once a good image is loaded (core released)
//   loading    - 1 while a frame is in progress
//   error      - sticky checksum/framing/timeout error, cleared by a new sync byte
module k12a_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int unsigned TIMEOUT_CLKS = 65535
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        cpu_run,
  output logic        loading,
  output logic        error
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS);
  localparam logic [7:0]       SYNC_BYTE = 8'h55;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_WAIT_SYNC,
    L_LEN_HI,
    L_LEN_LO,
    L_DATA,
    L_CHECK,
    L_RUN,
    L_ERROR
  } ld_state_t;

  // ---------------- RX path ----------------
  rx_state_t        rx_state, rx_state_d;
  logic             rx_s1, rx_s2, rx_d;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;
  logic             rx_fall_c;
  logic             half_tick_c;
  logic             bit_tick_c;

  // Edge (not level) detect so a low stop bit cannot retrigger a start.
  assign rx_fall_c   = rx_d & ~rx_s2;
  assign half_tick_c = (clk_cnt == HALF_LAST);
  assign bit_tick_c  = (clk_cnt == BIT_LAST);

  // RX next-state
  always_comb begin
    rx_state_d = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall_c) rx_state_d = RX_START;
      RX_START: if (half_tick_c) rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick_c && (bit_idx == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (bit_tick_c) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_state_d;
  end

  // RX synchroniser, bit timing and byte assembly
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if ((rx_state_d != rx_state) || bit_tick_c) clk_cnt <= '0;
      else                                          clk_cnt <= CNT_W'(clk_cnt + 1'b1);

      if (rx_state == RX_START) bit_idx <= '0;

      if ((rx_state == RX_DATA) && bit_tick_c) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_idx  <= 3'(bit_idx + 3'd1);
      end

      if ((rx_state == RX_STOP) && bit_tick_c) begin
        if (rx_s2) begin
          byte_valid <= 1'b1;
          rx_byte    <= rx_shift;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  // ---------------- Loader ----------------
  ld_state_t       ld_state, ld_state_d;
  logic [15:0]     len;
  logic [15:0]     cnt;
  logic [7:0]      sum;
  logic [TO_W-1:0] idle_cnt;
  logic            in_frame_c;
  logic            in_frame_d_c;

  assign in_frame_c   = ld_state inside {L_LEN_HI, L_LEN_LO, L_DATA, L_CHECK};
  assign in_frame_d_c = ld_state_d inside {L_LEN_HI, L_LEN_LO, L_DATA, L_CHECK};

  // Loader next-state; frame errors and timeout override byte handling mid-frame
  always_comb begin
    ld_state_d = ld_state;
    case (ld_state)
      L_WAIT_SYNC: if (byte_valid && (rx_byte == SYNC_BYTE)) ld_state_d = L_LEN_HI;
      L_LEN_HI:    if (byte_valid) ld_state_d = L_LEN_LO;
      L_LEN_LO:    if (byte_valid) ld_state_d = ({len[15:8], rx_byte} == 16'd0) ? L_CHECK : L_DATA;
      L_DATA:      if (byte_valid && (16'(cnt + 16'd1) == len)) ld_state_d = L_CHECK;
      L_CHECK:     if (byte_valid) ld_state_d = (rx_byte == sum) ? L_RUN : L_ERROR;
      L_RUN,
      L_ERROR:     if (byte_valid && (rx_byte == SYNC_BYTE)) ld_state_d = L_LEN_HI;
      default:     ld_state_d = L_WAIT_SYNC;
    endcase
    if (in_frame_c) begin
      if (frame_err) ld_state_d = L_ERROR;
      else if (!byte_valid && (idle_cnt == TO_LAST)) ld_state_d = L_ERROR;
    end
  end

  // Loader state register
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) ld_state <= L_WAIT_SYNC;
    else          ld_state <= ld_state_d;
  end

  // Loader datapath and registered outputs (status flags track the next state)
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      len      <= '0;
      cnt      <= '0;
      sum      <= '0;
      idle_cnt <= '0;
      mem_addr <= BASE_ADDR;
      mem_data <= '0;
      mem_we   <= 1'b0;
      cpu_run  <= 1'b0;
      loading  <= 1'b0;
      error    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_run <= (ld_state_d == L_RUN);
      loading <= in_frame_d_c;
      error   <= (ld_state_d == L_ERROR);

      if (byte_valid || !in_frame_c) idle_cnt <= '0;
      else if (idle_cnt != TO_LAST)  idle_cnt <= TO_W'(idle_cnt + 1'b1);

      if (byte_valid) begin
        case (ld_state)
          L_LEN_HI: len[15:8] <= rx_byte;
          L_LEN_LO: begin
            len[7:0] <= rx_byte;
            sum      <= '0;
            cnt      <= '0;
            mem_addr <= BASE_ADDR;
          end
          L_DATA: begin
            mem_we   <= 1'b1;
            mem_data <= rx_byte;
            mem_addr <= 16'(BASE_ADDR + cnt);
            sum      <= 8'(sum + rx_byte);
            cnt      <= 16'(cnt + 16'd1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
